// File: rtl/lfsr_parity_gen.sv
// Parametrised Fibonacci LFSR with registered parity, seed load, lock-up recovery and period-wrap pulse.
// Optional period measurement counter is enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_parity_gen #(
  parameter int             W          = 7,
  parameter logic [W-1:0]   TAPS       = 7'b1100000,
  parameter logic [W-1:0]   SEED       = 7'b0000001,
  parameter bit             PARITY_ODD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] seed_in,
  output logic [W:0]   lfsr_out,
  output logic         period_done,
  output logic         lockup_fix
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [W-1:0] period_len,
  output logic         period_valid
`endif
);

  logic [W-1:0] state_q, state_d;
  logic [W-1:0] start_q, start_d;
  logic         parity_q, parity_d;
  logic         period_done_q, period_done_d;
  logic         lockup_fix_q, lockup_fix_d;
  logic [W-1:0] step_nxt;
  logic         restart;
  logic         stepped;

  assign step_nxt = {state_q[W-2:0], ^(state_q & TAPS)};

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    period_done_d = 1'b0;
    lockup_fix_d  = 1'b0;
    restart       = 1'b0;
    stepped       = 1'b0;
    if (load) begin
      // A zero seed would lock the register, so it is swapped for SEED.
      state_d      = (seed_in != '0) ? seed_in : SEED;
      start_d      = state_d;
      lockup_fix_d = (seed_in == '0);
      restart      = 1'b1;
    end else if (en) begin
      if (state_q == '0) begin
        state_d      = SEED;
        start_d      = SEED;
        lockup_fix_d = 1'b1;
        restart      = 1'b1;
      end else begin
        state_d       = step_nxt;
        period_done_d = (step_nxt == start_q);
        stepped       = 1'b1;
      end
    end
    parity_d = (^state_d) ^ PARITY_ODD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEED;
      start_q       <= SEED;
      parity_q      <= (^SEED) ^ PARITY_ODD;
      period_done_q <= 1'b0;
      lockup_fix_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      parity_q      <= parity_d;
      period_done_q <= period_done_d;
      lockup_fix_q  <= lockup_fix_d;
    end
  end

  assign lfsr_out    = {parity_q, state_q};
  assign period_done = period_done_q;
  assign lockup_fix  = lockup_fix_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] period_len_q, period_len_d;
  logic         period_valid_q, period_valid_d;

  // Saturating +1 so very long periods report 2^W-1 rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    cnt_d          = cnt_q;
    period_len_d   = period_len_q;
    period_valid_d = period_valid_q;
    if (restart) begin
      cnt_d = '0;
    end else if (stepped) begin
      if (period_done_d) begin
        period_len_d   = cnt_inc;
        period_valid_d = 1'b1;
        cnt_d          = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      period_len_q   <= '0;
      period_valid_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_len_q   <= period_len_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign period_len   = period_len_q;
  assign period_valid = period_valid_q;
`else
  logic unused_ok;
  assign unused_ok = restart & stepped;
`endif

endmodule
